// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module : bus_pkg
// Brief  : Dual-rail codeword type, constants, word predicates, FSM states.
// Rev    : 1.0
// ============================================================================
package bus_pkg;

    typedef struct packed {
        logic t;
        logic f;
    } Dual;

    localparam Dual DUAL_NULL = '{t: 1'b0, f: 1'b0};
    localparam Dual DUAL_ONE  = '{t: 1'b1, f: 1'b0};
    localparam Dual DUAL_ZERO = '{t: 1'b0, f: 1'b1};

    // Predicates take a word zero-padded (NULL) up to DUAL_MAX bits.
    localparam int DUAL_MAX = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELIVER = 2'd1,
        RETURN  = 2'd2
    } state_e;

    function automatic logic dual_complete(input Dual [DUAL_MAX-1:0] w, input int n);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DUAL_MAX; i++) begin
            if (i < n && w[i] != DUAL_ONE && w[i] != DUAL_ZERO) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic dual_null(input Dual [DUAL_MAX-1:0] w);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DUAL_MAX; i++) begin
            if (w[i] != DUAL_NULL) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic dual_illegal(input Dual [DUAL_MAX-1:0] w);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DUAL_MAX; i++) begin
            if (w[i].t && w[i].f) bad = 1'b1;
        end
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module : bus_tag_fifo
// Brief  : 1-bit wide, DEPTH-deep synchronous FIFO of user tags.
// Rev    : 1.0
// ============================================================================
module bus_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push_i,
    input  logic data_i,
    input  logic pop_i,
    output logic data_o,
    output logic full_o,
    output logic empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, rd_q;
    logic [DEPTH-1:0] mem_q;
    logic             w_do_pop, w_do_push;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    // A pop frees the slot in the same cycle, so a full FIFO still takes a push then.
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (w_do_push) wr_q <= wr_q + 1'b1;
            if (w_do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/bus2_return.sv
`default_nettype none
// ============================================================================
// Module : bus2_return
// Brief  : Routes dual-rail results back to the requesting user in tag order.
// Rev    : 1.0
// ============================================================================
module bus2_return
    import bus_pkg::*;
#(
    parameter int OUTPUT = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              grant_valid,
    input  logic              grant_user,
    output logic              grant_ready,
    input  Dual [OUTPUT-1:0]  output_word,
    output logic              output_ack,
    output Dual [OUTPUT-1:0]  user0_output,
    output Dual [OUTPUT-1:0]  user1_output,
    input  logic              user0_ack,
    input  logic              user1_ack,
    output logic              protocol_error
);
    state_e             state_q, state_d;
    Dual [OUTPUT-1:0]   word_q, word_d;
    logic               user_q, user_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;

    Dual [DUAL_MAX-1:0] w_word_pad;
    logic               w_complete, w_null, w_illegal;
    logic               w_sel_ack, w_pop, w_head, w_full, w_empty;

    bus_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (grant_valid),
        .data_i  (grant_user),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    always_comb begin
        w_word_pad             = '0;
        w_word_pad[OUTPUT-1:0] = output_word;
    end

    assign w_complete = dual_complete(w_word_pad, OUTPUT);
    assign w_null     = dual_null(w_word_pad);
    assign w_illegal  = dual_illegal(w_word_pad);
    assign w_sel_ack  = user_q ? user1_ack : user0_ack;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        user_d  = user_q;
        ack_d   = ack_q;
        err_d   = err_q;
        w_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_illegal) err_d = 1'b1;
                if (w_complete && !w_empty) begin
                    word_d  = output_word;
                    user_d  = w_head;
                    ack_d   = 1'b1;
                    state_d = DELIVER;
                end
            end
            DELIVER: begin
                if (w_sel_ack) state_d = RETURN;
            end
            RETURN: begin
                if (w_illegal) err_d = 1'b1;
                if (w_null) ack_d = 1'b0;
                if (w_null && !w_sel_ack) begin
                    state_d = IDLE;
                    w_pop   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            user_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            user_q  <= user_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign user0_output   = (state_q == DELIVER && !user_q) ? word_q : '0;
    assign user1_output   = (state_q == DELIVER &&  user_q) ? word_q : '0;
    assign output_ack     = ack_q;
    assign protocol_error = err_q;
    assign grant_ready    = !w_full;

endmodule
`default_nettype wire

// File: tb/tb_bus2_return.sv
`default_nettype none
// ============================================================================
// Module : tb_bus2_return
// Brief  : Directed self-checking bench for bus2_return (OUTPUT=4, DEPTH=4).
// Rev    : 1.0
// ============================================================================
module tb_bus2_return;
    logic       clk = 1'b0;
    logic       reset, grant_valid, grant_user, grant_ready;
    logic [7:0] out_w, u0, u1;
    logic       output_ack, u0_ack, u1_ack, perr;
    int         pass_cnt = 0;
    int         total_cnt = 0;

    always #5 clk = ~clk;

    bus2_return #(.OUTPUT(4), .DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .grant_valid    (grant_valid),
        .grant_user     (grant_user),
        .grant_ready    (grant_ready),
        .output_word    (out_w),
        .output_ack     (output_ack),
        .user0_output   (u0),
        .user1_output   (u1),
        .user0_ack      (u0_ack),
        .user1_ack      (u1_ack),
        .protocol_error (perr)
    );

    function automatic logic [7:0] enc(input logic [3:0] b);
        logic [7:0] v;
        for (int i = 0; i < 4; i++) begin
            v[2*i+1] = b[i];
            v[2*i]   = ~b[i];
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tag(input logic user);
        grant_valid = 1'b1;
        grant_user  = user;
        tick();
        grant_valid = 1'b0;
    endtask

    // Full transfer to a user whose tag is already at the FIFO head; state IDLE.
    task automatic deliver(input logic user, input logic [3:0] bits);
        out_w = enc(bits);
        tick();
        total_cnt++;
        if ((user ? u1 : u0) !== enc(bits)) $display("FAIL deliver_sel got=%h exp=%h", (user ? u1 : u0), enc(bits));
        else pass_cnt++;
        total_cnt++;
        if ((user ? u0 : u1) !== 8'h00) $display("FAIL deliver_other got=%h exp=00", (user ? u0 : u1));
        else pass_cnt++;
        total_cnt++;
        if (output_ack !== 1'b1) $display("FAIL deliver_ack got=%b exp=1", output_ack);
        else pass_cnt++;
        if (user) u0_ack = 1'b1; else u1_ack = 1'b1;
        tick();
        u0_ack = 1'b0;
        u1_ack = 1'b0;
        total_cnt++;
        if ((user ? u1 : u0) !== enc(bits)) $display("FAIL deliver_ignore_other_ack got=%h exp=%h", (user ? u1 : u0), enc(bits));
        else pass_cnt++;
        out_w = 8'h00;
        if (user) u1_ack = 1'b1; else u0_ack = 1'b1;
        tick();
        total_cnt++;
        if ((user ? u1 : u0) !== 8'h00) $display("FAIL return_null got=%h exp=00", (user ? u1 : u0));
        else pass_cnt++;
        u0_ack = 1'b0;
        u1_ack = 1'b0;
        tick();
        total_cnt++;
        if (output_ack !== 1'b0) $display("FAIL return_ack_low got=%b exp=0", output_ack);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1; grant_valid = 1'b0; grant_user = 1'b0;
        out_w = 8'h00; u0_ack = 1'b0; u1_ack = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        total_cnt++;
        if (output_ack !== 1'b0) $display("FAIL reset_ack got=%b exp=0", output_ack); else pass_cnt++;
        total_cnt++;
        if (u0 !== 8'h00) $display("FAIL reset_u0 got=%h exp=00", u0); else pass_cnt++;
        total_cnt++;
        if (u1 !== 8'h00) $display("FAIL reset_u1 got=%h exp=00", u1); else pass_cnt++;
        total_cnt++;
        if (perr !== 1'b0) $display("FAIL reset_perr got=%b exp=0", perr); else pass_cnt++;
        total_cnt++;
        if (grant_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", grant_ready); else pass_cnt++;
    endtask

    task automatic test_single();
        push_tag(1'b0);
        out_w = enc(4'b1010);
        tick();
        total_cnt++;
        if (u0 !== enc(4'b1010)) $display("FAIL single_u0 got=%h exp=%h", u0, enc(4'b1010)); else pass_cnt++;
        total_cnt++;
        if (u1 !== 8'h00) $display("FAIL single_u1 got=%h exp=00", u1); else pass_cnt++;
        total_cnt++;
        if (output_ack !== 1'b1) $display("FAIL single_ack got=%b exp=1", output_ack); else pass_cnt++;
        u0_ack = 1'b1;
        tick();
        total_cnt++;
        if (u0 !== 8'h00) $display("FAIL single_u0_return got=%h exp=00", u0); else pass_cnt++;
        tick();
        total_cnt++;
        if (output_ack !== 1'b1) $display("FAIL single_ack_hold got=%b exp=1", output_ack); else pass_cnt++;
        out_w = 8'h00;
        tick();
        total_cnt++;
        if (output_ack !== 1'b0) $display("FAIL single_ack_drop got=%b exp=0", output_ack); else pass_cnt++;
        u0_ack = 1'b0;
        tick();
        out_w = enc(4'b1010);
        tick(); tick();
        total_cnt++;
        if (output_ack !== 1'b0 || u0 !== 8'h00) $display("FAIL single_fifo_empty got=%b/%h exp=0/00", output_ack, u0); else pass_cnt++;
        out_w = 8'h00;
        tick();
    endtask

    task automatic test_order();
        push_tag(1'b1);
        push_tag(1'b0);
        push_tag(1'b1);
        deliver(1'b1, 4'b0001);
        deliver(1'b0, 4'b1111);
        deliver(1'b1, 4'b0110);
    endtask

    task automatic test_empty_fifo();
        int bad;
        bad = 0;
        out_w = enc(4'b0011);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (output_ack !== 1'b0 || u0 !== 8'h00 || u1 !== 8'h00) bad++;
        end
        total_cnt++;
        if (bad != 0) $display("FAIL empty_no_capture got=%0d bad cycles exp=0", bad); else pass_cnt++;
        push_tag(1'b0);
        tick();
        total_cnt++;
        if (u0 !== enc(4'b0011)) $display("FAIL empty_late_tag got=%h exp=%h", u0, enc(4'b0011)); else pass_cnt++;
        out_w = 8'h00; u0_ack = 1'b1;
        tick();
        u0_ack = 1'b0;
        tick();
        total_cnt++;
        if (output_ack !== 1'b0) $display("FAIL empty_finish_ack got=%b exp=0", output_ack); else pass_cnt++;
    endtask

    task automatic test_full();
        push_tag(1'b0); push_tag(1'b1); push_tag(1'b1); push_tag(1'b0);
        total_cnt++;
        if (grant_ready !== 1'b0) $display("FAIL full_ready got=%b exp=0", grant_ready); else pass_cnt++;
        push_tag(1'b1);
        out_w = enc(4'b0101);
        tick();
        total_cnt++;
        if (u0 !== enc(4'b0101)) $display("FAIL full_head got=%h exp=%h", u0, enc(4'b0101)); else pass_cnt++;
        out_w = 8'h00; u0_ack = 1'b1;
        tick();
        u0_ack = 1'b0;
        grant_valid = 1'b1; grant_user = 1'b1;
        tick();
        grant_valid = 1'b0;
        total_cnt++;
        if (grant_ready !== 1'b0) $display("FAIL full_push_pop got=%b exp=0", grant_ready); else pass_cnt++;
        deliver(1'b1, 4'b1000);
        total_cnt++;
        if (grant_ready !== 1'b1) $display("FAIL full_ready_back got=%b exp=1", grant_ready); else pass_cnt++;
        deliver(1'b1, 4'b0100);
        deliver(1'b0, 4'b0010);
        deliver(1'b1, 4'b1110);
        out_w = enc(4'b0001);
        tick(); tick();
        total_cnt++;
        if (output_ack !== 1'b0) $display("FAIL full_drop_fifth got=%b exp=0", output_ack); else pass_cnt++;
        out_w = 8'h00;
        tick();
    endtask

    task automatic test_illegal();
        push_tag(1'b0);
        out_w = 8'b10_11_01_10;
        tick();
        total_cnt++;
        if (perr !== 1'b1) $display("FAIL illegal_flag got=%b exp=1", perr); else pass_cnt++;
        total_cnt++;
        if (output_ack !== 1'b0 || u0 !== 8'h00) $display("FAIL illegal_no_capture got=%b/%h exp=0/00", output_ack, u0); else pass_cnt++;
        out_w = 8'h00;
        tick(); tick();
        total_cnt++;
        if (perr !== 1'b1) $display("FAIL illegal_sticky got=%b exp=1", perr); else pass_cnt++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total_cnt++;
        if (perr !== 1'b0) $display("FAIL illegal_reset_clear got=%b exp=0", perr); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        push_tag(1'b1);
        push_tag(1'b0);
        out_w = enc(4'b1100);
        tick();
        total_cnt++;
        if (u1 !== enc(4'b1100)) $display("FAIL mid_deliver got=%h exp=%h", u1, enc(4'b1100)); else pass_cnt++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total_cnt++;
        if (u0 !== 8'h00 || u1 !== 8'h00) $display("FAIL mid_outputs got=%h/%h exp=00/00", u0, u1); else pass_cnt++;
        total_cnt++;
        if (output_ack !== 1'b0) $display("FAIL mid_ack got=%b exp=0", output_ack); else pass_cnt++;
        total_cnt++;
        if (grant_ready !== 1'b1) $display("FAIL mid_ready got=%b exp=1", grant_ready); else pass_cnt++;
        tick(); tick();
        total_cnt++;
        if (output_ack !== 1'b0 || u0 !== 8'h00 || u1 !== 8'h00) $display("FAIL mid_fifo_empty got=%b/%h/%h exp=0/00/00", output_ack, u0, u1); else pass_cnt++;
        out_w = 8'h00;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_order();
        test_empty_fifo();
        test_full();
        test_illegal();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
